// File: rtl/bk_operand_recover.sv
// Digit-serial operand recovery B = S - A for the Brent-Kung adder path.
// Optional abort input enabled by defining BK_OPERAND_RECOVER_ABORT_EN.
module bk_operand_recover #(
   parameter int WIDTH   = 12,
   parameter int DIGIT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef BK_OPERAND_RECOVER_ABORT_EN
   input  logic             abort_i,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   sum_i,
   input  logic [WIDTH-1:0] opa_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] opb_o,
   output logic             err_o
);

   localparam int N  = (WIDTH + DIGIT_W) / DIGIT_W;
   localparam int PW = N * DIGIT_W;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state;
   logic [PW-1:0]   s_sh;
   logic [PW-1:0]   a_sh;
   logic [PW-1:0]   res;
   logic            borrow;
   logic [CW-1:0]   cnt;
   logic            abort;
   logic [DIGIT_W:0] dif;
   logic [PW-1:0]   res_nx;

`ifdef BK_OPERAND_RECOVER_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // Top bit of dif is the borrow out of the current digit.
   always_comb begin
      dif = {1'b0, s_sh[DIGIT_W-1:0]}
          - {1'b0, a_sh[DIGIT_W-1:0]}
          - {{DIGIT_W{1'b0}}, borrow};
   end

   generate
      if (N > 1) begin : g_shift
         assign res_nx = {dif[DIGIT_W-1:0], res[PW-1:DIGIT_W]};
      end else begin : g_single
         assign res_nx = dif[DIGIT_W-1:0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s_sh      <= '0;
         a_sh      <= '0;
         res       <= '0;
         borrow    <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         opb_o     <= '0;
         err_o     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  s_sh     <= PW'(sum_i);
                  a_sh     <= PW'(opa_i);
                  res      <= '0;
                  borrow   <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (abort) begin
                  state     <= IDLE;
                  res       <= '0;
                  borrow    <= 1'b0;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  opb_o     <= '0;
                  err_o     <= 1'b0;
               end else begin
                  s_sh   <= s_sh >> DIGIT_W;
                  a_sh   <= a_sh >> DIGIT_W;
                  res    <= res_nx;
                  borrow <= dif[DIGIT_W];
                  cnt    <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     // Final borrow also catches borrows through the pad bits.
                     state     <= DONE;
                     out_valid <= 1'b1;
                     opb_o     <= res_nx[WIDTH-1:0];
                     err_o     <= dif[DIGIT_W] | res_nx[WIDTH];
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  state     <= IDLE;
                  res       <= '0;
                  borrow    <= 1'b0;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  opb_o     <= '0;
                  err_o     <= 1'b0;
               end else if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bk_operand_recover.sv
// Self-checking bench for bk_operand_recover against an integer S - A model.
// Abort checks are built when BK_OPERAND_RECOVER_ABORT_EN is defined.
module tb_bk_operand_recover;

   localparam int WIDTH = 12;
   localparam int N     = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [12:0] sum_i = '0;
   logic [11:0] opa_i = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] opb_o;
   logic        err_o;
`ifdef BK_OPERAND_RECOVER_ABORT_EN
   logic        abort_i = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bk_operand_recover #(.WIDTH(WIDTH), .DIGIT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef BK_OPERAND_RECOVER_ABORT_EN
      .abort_i   (abort_i),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_i     (sum_i),
      .opa_i     (opa_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .opb_o     (opb_o),
      .err_o     (err_o)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain integer model: B = (S - A) mod 2^WIDTH, error when out of range.
   function automatic void ref_model(input int s, input int a,
                                     output int b, output int e);
      int d;
      d = s - a;
      b = ((d % 4096) + 4096) % 4096;
      e = (d < 0 || d > 4095) ? 1 : 0;
   endfunction

   task automatic issue(input int s, input int a);
      int g;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("accept_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      sum_i    = 13'(s);
      opa_i    = 12'(a);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sum_i    = 13'($urandom);
      opa_i    = 12'($urandom);
   endtask

   task automatic wait_done();
      int lat;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, N);
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_out_valid", int'(out_valid), 0);
      check("hs_in_ready", int'(in_ready), 1);
   endtask

   task automatic run_req(input string tag, input int s, input int a);
      int b;
      int e;
      ref_model(s, a, b, e);
      issue(s, a);
      wait_done();
      check({tag, "_opb"}, int'(opb_o), b);
      check({tag, "_err"}, int'(err_o), e);
      handshake();
   endtask

   initial begin
      int b;
      int e;
      int s;
      int a;
      int seen;

      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_opb", int'(opb_o), 0);
      check("rst_err", int'(err_o), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_req("wrap", 'h1000, 'h001);
      run_req("s_lt_a", 'h0005, 'h007);
      run_req("max_ok", 'h1FFE, 'hFFF);
      run_req("b_ovf", 'h1FFF, 'h000);
      run_req("zero", 'h0000, 'h000);

      // Hold the result while new requests knock on the input.
      ref_model('h0ABC, 'h0123, b, e);
      issue('h0ABC, 'h0123);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         sum_i    = 13'($urandom);
         opa_i    = 12'($urandom);
         @(posedge clk);
         #1;
         check("stall_opb", int'(opb_o), b);
         check("stall_err", int'(err_o), e);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
      end
      in_valid = 1'b0;
      handshake();
      seen = 0;
      repeat (N + 3) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("ignored_req", seen, 0);

      // Asynchronous reset mid-computation.
      issue('h0123, 'h0011);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", int'(in_ready), 1);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_opb", int'(opb_o), 0);
      check("arst_err", int'(err_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req("post_rst", 'h0100, 'h0FF);

      for (int i = 0; i < 24; i++) begin
         a = int'($urandom_range(0, 4095));
         if (i % 3 == 0)
            s = a + int'($urandom_range(0, 4095));
         else
            s = int'($urandom_range(0, 8191));
         run_req("rand", s, a);
      end

`ifdef BK_OPERAND_RECOVER_ABORT_EN
      run_req("pre_abort", 'h1FFE, 'hFFF);
      issue('h0345, 'h0012);
      repeat (3) @(posedge clk);
      @(negedge clk);
      abort_i = 1'b1;
      @(posedge clk);
      #1;
      abort_i = 1'b0;
      check("abort_calc_opb", int'(opb_o), 0);
      check("abort_calc_rdy", int'(in_ready), 1);
      seen = 0;
      repeat (N + 3) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("abort_calc_nov", seen, 0);

      issue('h1FFE, 'hFFF);
      wait_done();
      @(negedge clk);
      abort_i   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      abort_i   = 1'b0;
      out_ready = 1'b0;
      check("abort_done_opb", int'(opb_o), 0);
      check("abort_done_ov", int'(out_valid), 0);
      check("abort_done_rdy", int'(in_ready), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
